// File: rtl/thiele_cpu.sv
// Multi-cycle Thiele-machine sequencer: fetch/decode/execute with a 3-cycle
// memory transfer and req/ack handshakes to a logic engine and a Python bridge.
module thiele_cpu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_data,
  output logic [31:0] pc,
  output logic [31:0] cert_addr,
  output logic [31:0] status,
  output logic [31:0] error_code,
  output logic [31:0] partition_ops,
  output logic [31:0] mdl_ops,
  output logic [31:0] info_gain,
  output logic [31:0] mu,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_en,
  output logic        logic_req,
  output logic [31:0] logic_addr,
  input  logic        logic_ack,
  input  logic [31:0] logic_data,
  output logic        py_req,
  output logic [31:0] py_code_addr,
  input  logic        py_ack,
  input  logic [31:0] py_result
);

  // Opcode map shared with the toolchain's generated opcode table.
  localparam logic [7:0] OpPnew    = 8'h00;
  localparam logic [7:0] OpPsplit  = 8'h01;
  localparam logic [7:0] OpPmerge  = 8'h02;
  localparam logic [7:0] OpLassert = 8'h03;
  localparam logic [7:0] OpMdlacc  = 8'h05;
  localparam logic [7:0] OpXfer    = 8'h07;
  localparam logic [7:0] OpPyexec  = 8'h08;
  localparam logic [7:0] OpEmit    = 8'h0E;
  localparam logic [7:0] OpHalt    = 8'hFF;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StExecute  = 4'd2,
    StMemory   = 4'd3,
    StLogic    = 4'd4,
    StPython   = 4'd5,
    StComplete = 4'd6
  } state_e;

  // state and opcode keep these exact names so benches can probe them.
  state_e      state;
  state_e      w_state_next;
  logic [7:0]  opcode;

  logic [31:0] r_instr;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [7:0]  r_cost;
  logic [1:0]  r_mem_phase;
  logic [31:0] r_mem_data;
  // Set after the first wait cycle so a stale ack is never taken on entry.
  logic        r_req_seen;

  logic [31:0] r_pc, r_cert_addr, r_status, r_error_code;
  logic [31:0] r_partition_ops, r_mdl_ops, r_info_gain, r_mu;
  logic [31:0] w_ab;

  assign w_ab          = {16'h0, r_a, r_b};
  assign pc            = r_pc;
  assign cert_addr     = r_cert_addr;
  assign status        = r_status;
  assign error_code    = r_error_code;
  assign partition_ops = r_partition_ops;
  assign mdl_ops       = r_mdl_ops;
  assign info_gain     = r_info_gain;
  assign mu            = r_mu;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= StFetch;
    else        state <= w_state_next;
  end

  // Next-state decode plus memory and handshake outputs.
  always_comb begin
    w_state_next = state;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    logic_req    = 1'b0;
    logic_addr   = '0;
    py_req       = 1'b0;
    py_code_addr = '0;
    case (state)
      StFetch:  w_state_next = StDecode;
      StDecode: w_state_next = StExecute;
      StExecute: begin
        case (opcode)
          OpXfer:    w_state_next = StMemory;
          OpLassert: w_state_next = StLogic;
          OpPyexec:  w_state_next = StPython;
          OpHalt:    w_state_next = StExecute;
          default:   w_state_next = StComplete;
        endcase
      end
      StMemory: begin
        if (r_mem_phase == 2'd0) begin
          mem_en   = 1'b1;
          mem_addr = {24'h0, r_a};
        end else if (r_mem_phase == 2'd2) begin
          mem_en       = 1'b1;
          mem_we       = 1'b1;
          mem_addr     = {24'h0, r_b};
          mem_wdata    = r_mem_data;
          w_state_next = StComplete;
        end
      end
      StLogic: begin
        logic_req  = 1'b1;
        logic_addr = w_ab;
        if (r_req_seen && logic_ack) w_state_next = StComplete;
      end
      StPython: begin
        py_req       = 1'b1;
        py_code_addr = w_ab;
        if (r_req_seen && py_ack) w_state_next = StComplete;
      end
      StComplete: w_state_next = StFetch;
      default:    w_state_next = StFetch;
    endcase
  end

  // Instruction latch, operand fields and architectural register updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode          <= '0;
      r_instr         <= '0;
      r_a             <= '0;
      r_b             <= '0;
      r_cost          <= '0;
      r_mem_phase     <= '0;
      r_mem_data      <= '0;
      r_req_seen      <= 1'b0;
      r_pc            <= '0;
      r_cert_addr     <= '0;
      r_status        <= '0;
      r_error_code    <= '0;
      r_partition_ops <= '0;
      r_mdl_ops       <= '0;
      r_info_gain     <= '0;
      r_mu            <= '0;
    end else begin
      case (state)
        StFetch: r_instr <= instr_data;
        StDecode: begin
          opcode <= r_instr[31:24];
          r_a    <= r_instr[23:16];
          r_b    <= r_instr[15:8];
          r_cost <= r_instr[7:0];
        end
        StExecute: begin
          case (opcode)
            OpPnew, OpPsplit, OpPmerge: r_partition_ops <= r_partition_ops + 32'd1;
            OpMdlacc: r_mdl_ops <= r_mdl_ops + 32'd1;
            OpEmit: begin
              r_info_gain <= r_info_gain + {24'h0, r_b};
              r_cert_addr <= w_ab;
            end
            OpHalt:  r_status[0] <= 1'b1;
            default: ;
          endcase
        end
        StMemory: begin
          if (r_mem_phase == 2'd1) r_mem_data <= mem_rdata;
          r_mem_phase <= (r_mem_phase == 2'd2) ? 2'd0 : r_mem_phase + 2'd1;
        end
        StLogic: begin
          if (r_req_seen && logic_ack) begin
            r_info_gain <= r_info_gain + logic_data;
            r_req_seen  <= 1'b0;
          end else begin
            r_req_seen <= 1'b1;
          end
        end
        StPython: begin
          if (r_req_seen && py_ack) begin
            r_req_seen <= 1'b0;
            // A nonzero bridge result is recorded but does not stop execution.
            if (py_result != 32'd0) begin
              r_error_code <= py_result;
              r_status[1]  <= 1'b1;
            end
          end else begin
            r_req_seen <= 1'b1;
          end
        end
        StComplete: begin
          r_mu <= r_mu + {24'h0, r_cost};
          r_pc <= r_pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_thiele_cpu.sv
// Bench for thiele_cpu: straight-line programs with an instruction-level model,
// bridge/engine responders, a data memory, and directed literal cases.
module tb_thiele_cpu;

  typedef struct packed {
    logic [31:0] cert, status, ec, po, mdl, ig, mu;
  } arch_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_data, pc, cert_addr, status, error_code;
  logic [31:0] partition_ops, mdl_ops, info_gain, mu;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_en;
  logic        logic_req, logic_ack, py_req, py_ack;
  logic [31:0] logic_addr, logic_data, py_code_addr, py_result;

  logic [31:0] prog [0:63];
  logic [31:0] pyv [0:63];
  logic [31:0] lgv [0:63];
  int          dly [0:63];
  logic [31:0] dm_init [0:255];
  logic [31:0] dmem [0:255];
  logic [31:0] mdm [0:255];

  arch_t       exp_arch [0:64];
  arch_t       exp_final;
  logic [7:0]  exp_waddr [0:63];
  logic [31:0] exp_wdata [0:63];
  int          halt_idx;

  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  bit          dm_load = 1'b0;
  bit          resp_en = 1'b1;
  bit          halted, halt_wait, py_prev, lg_prev;
  logic [31:0] py_log [$];
  int          lg_hi, lg_rise;

  always #5 clk = ~clk;
  assign instr_data = prog[pc[7:2]];

  thiele_cpu dut (
    .clk(clk), .rst_n(rst_n), .instr_data(instr_data), .pc(pc),
    .cert_addr(cert_addr), .status(status), .error_code(error_code),
    .partition_ops(partition_ops), .mdl_ops(mdl_ops), .info_gain(info_gain), .mu(mu),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_en(mem_en),
    .logic_req(logic_req), .logic_addr(logic_addr), .logic_ack(logic_ack),
    .logic_data(logic_data),
    .py_req(py_req), .py_code_addr(py_code_addr), .py_ack(py_ack), .py_result(py_result)
  );

  // Synchronous data memory: read data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (dm_load) begin
      for (int i = 0; i < 256; i++) dmem[i] <= dm_init[i];
    end else if (mem_en) begin
      if (mem_we) dmem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= dmem[mem_addr[7:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_arch(input string tag, input arch_t e);
    chk({tag, ".cert_addr"}, cert_addr, e.cert);
    chk({tag, ".status"}, status, e.status);
    chk({tag, ".error_code"}, error_code, e.ec);
    chk({tag, ".partition_ops"}, partition_ops, e.po);
    chk({tag, ".mdl_ops"}, mdl_ops, e.mdl);
    chk({tag, ".info_gain"}, info_gain, e.ig);
    chk({tag, ".mu"}, mu, e.mu);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pc"}, pc, 32'h0);
    chk_arch(tag, '0);
    chk({tag, ".mem_addr"}, mem_addr, 32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, ".logic_addr"}, logic_addr, 32'h0);
    chk({tag, ".py_code_addr"}, py_code_addr, 32'h0);
    chk({tag, ".strobes"}, {28'h0, mem_en, mem_we, logic_req, py_req}, 32'h0);
    chk({tag, ".state"}, 32'(dut.state), 32'h0);
    chk({tag, ".opcode"}, 32'(dut.opcode), 32'h0);
  endtask

  // Instruction-level model: walks the straight-line program until HALT.
  task automatic build_model();
    arch_t s;
    s = '0;
    halt_idx = -1;
    for (int i = 0; i < 256; i++) mdm[i] = dm_init[i];
    exp_arch[0] = s;
    for (int k = 0; k < 64; k++) begin
      logic [7:0] op, a, b, c;
      {op, a, b, c} = prog[k];
      exp_waddr[k] = b;
      exp_wdata[k] = 32'h0;
      if (op == 8'hFF) begin
        s.status[0] = 1'b1;
        exp_final = s;
        halt_idx = k;
        break;
      end
      case (op)
        8'h00, 8'h01, 8'h02: s.po = s.po + 1;
        8'h05: s.mdl = s.mdl + 1;
        8'h07: begin
          exp_wdata[k] = mdm[a];
          mdm[b] = mdm[a];
        end
        8'h03: s.ig = s.ig + lgv[k];
        8'h08: if (pyv[k] != 0) begin
          s.ec = pyv[k];
          s.status[1] = 1'b1;
        end
        8'h0E: begin
          s.ig = s.ig + 32'(b);
          s.cert = {16'h0, a, b};
        end
        default: ;
      endcase
      s.mu = s.mu + 32'(c);
      exp_arch[k + 1] = s;
    end
  endtask

  // Python bridge responder.
  initial begin : py_resp
    int cnt;
    cnt = 0;
    py_ack = 1'b0;
    py_result = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        py_ack = 1'b0;
        cnt = 0;
      end else if (py_ack && !py_req) begin
        py_ack = 1'b0;
      end else if (py_req && !py_ack && resp_en) begin
        if (cnt >= dly[pc[7:2]]) begin
          py_ack = 1'b1;
          py_result = pyv[pc[7:2]];
          cnt = 0;
        end else cnt++;
      end
    end
  end

  // Logic engine responder.
  initial begin : lg_resp
    int cnt;
    cnt = 0;
    logic_ack = 1'b0;
    logic_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        logic_ack = 1'b0;
        cnt = 0;
      end else if (logic_ack && !logic_req) begin
        logic_ack = 1'b0;
      end else if (logic_req && !logic_ack && resp_en) begin
        if (cnt >= dly[pc[7:2]]) begin
          logic_ack = 1'b1;
          logic_data = lgv[pc[7:2]];
          cnt = 0;
        end else cnt++;
      end
    end
  end

  // Request log for the directed handshake cases.
  always @(negedge clk) begin
    if (!rst_n) begin
      py_log.delete();
      lg_hi = 0;
      lg_rise = 0;
      py_prev = 1'b0;
      lg_prev = 1'b0;
    end else begin
      if (py_req && !py_prev) py_log.push_back(py_code_addr);
      if (logic_req) lg_hi++;
      if (logic_req && !lg_prev) lg_rise++;
      py_prev = py_req;
      lg_prev = logic_req;
    end
  end

  // Compare process: DUT outputs against the model on every running cycle.
  always @(negedge clk) begin : cmp
    int k;
    k = int'(pc[7:2]);
    if (!rst_n) begin
      halted = 1'b0;
      halt_wait = 1'b0;
    end else if (chk_en && !halted) begin
      chk("mem_en_outside_memory", 32'(mem_en && dut.state != 4'd3), 32'h0);
      chk("py_req_vs_state", 32'(py_req), 32'(dut.state == 4'd5));
      chk("logic_req_vs_state", 32'(logic_req), 32'(dut.state == 4'd4));
      if (dut.state == 4'd0) chk_arch("fetch", exp_arch[k]);
      if (mem_en && !mem_we) chk("mem_rd_addr", mem_addr, {24'h0, prog[k][23:16]});
      if (mem_en && mem_we) begin
        chk("mem_wr_addr", mem_addr, {24'h0, exp_waddr[k]});
        chk("mem_wr_data", mem_wdata, exp_wdata[k]);
      end
      if (py_req) chk("py_code_addr", py_code_addr, {16'h0, prog[k][23:8]});
      if (logic_req) chk("logic_addr", logic_addr, {16'h0, prog[k][23:8]});
      if (dut.state == 4'd2 && dut.opcode == 8'hFF) begin
        if (halt_wait) begin
          chk("halt.pc", pc, 32'(halt_idx * 4));
          chk_arch("halt", exp_final);
          halted = 1'b1;
        end
        halt_wait = 1'b1;
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) begin
      prog[i] = 32'hFF000000;
      pyv[i] = '0;
      lgv[i] = '0;
      dly[i] = 1;
    end
    for (int i = 0; i < 256; i++) dm_init[i] = $urandom;
  endtask

  task automatic run_prog(input string tag);
    int bad;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1 chk_zero({tag, ".reset"});
    dm_load = 1'b1;
    build_model();
    repeat (2) @(negedge clk);
    dm_load = 1'b0;
    chk_en = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 3000 && !halted; c++) @(negedge clk);
    if (!halted) begin
      errors++;
      checks++;
      $display("FAIL %s.timeout: actual=running required=halted", tag);
    end
    chk_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== mdm[i]) bad++;
    chk({tag, ".dmem_mismatches"}, 32'(bad), 32'h0);
  endtask

  task automatic random_prog();
    for (int k = 0; k < 40; k++) begin
      logic [7:0] op;
      case ($urandom_range(0, 9))
        0: op = 8'h00;
        1: op = 8'h01;
        2: op = 8'h02;
        3: op = 8'h03;
        4: op = 8'h05;
        5: op = 8'h07;
        6: op = 8'h08;
        7: op = 8'h0E;
        8: op = 8'h04;
        default: begin
          op = 8'($urandom_range(9, 254));
          if (op == 8'h0E) op = 8'h0D;
        end
      endcase
      prog[k] = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
      pyv[k] = ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom;
      lgv[k] = $urandom;
      dly[k] = $urandom_range(0, 3);
    end
  endtask

  initial begin : main
    bit found;

    // Two bridge calls then HALT.
    clear_prog();
    prog[0] = 32'h08000101;
    prog[1] = 32'h08000201;
    run_prog("r019");
    chk("r019.py_count", 32'(py_log.size()), 32'd2);
    if (py_log.size() == 2) begin
      chk("r019.py_addr0", py_log[0], 32'h1);
      chk("r019.py_addr1", py_log[1], 32'h2);
    end
    chk("r019.state", 32'(dut.state), 32'd2);
    chk("r019.opcode", 32'(dut.opcode), 32'hFF);
    chk("r019.pc", pc, 32'h8);
    chk("r019.mu", mu, 32'd2);
    chk("r019.status", status, 32'h1);
    chk("r019.error_code", error_code, 32'h0);

    // Bridge error keeps executing.
    clear_prog();
    prog[0] = 32'h08000300;
    pyv[0]  = 32'd5;
    prog[1] = 32'h0E000700;
    run_prog("r020");
    chk("r020.error_code", error_code, 32'd5);
    chk("r020.status", status, 32'h3);
    chk("r020.cert_addr", cert_addr, 32'h7);

    // Partition / MDL counters and mu accumulation.
    clear_prog();
    prog[0] = 32'h00000003;
    prog[1] = 32'h01000003;
    prog[2] = 32'h05000003;
    run_prog("r021");
    chk("r021.partition_ops", partition_ops, 32'd2);
    chk("r021.mdl_ops", mdl_ops, 32'd1);
    chk("r021.mu", mu, 32'd9);
    chk("r021.pc", pc, 32'hC);

    // EMIT.
    clear_prog();
    prog[0] = 32'h0E123400;
    run_prog("r022");
    chk("r022.cert_addr", cert_addr, 32'h1234);
    chk("r022.info_gain", info_gain, 32'h34);

    // Logic handshake with a 4-cycle ack delay.
    clear_prog();
    prog[0] = 32'h03000900;
    lgv[0]  = 32'd7;
    dly[0]  = 4;
    run_prog("r023");
    chk("r023.req_cycles", 32'(lg_hi), 32'd5);
    chk("r023.req_rises", 32'(lg_rise), 32'd1);
    chk("r023.info_gain", info_gain, 32'd7);
    chk("r023.logic_req_after", 32'(logic_req), 32'd0);

    // Randomized programs.
    for (int r = 0; r < 8; r++) begin
      clear_prog();
      random_prog();
      run_prog("rand");
    end

    // Reset in the middle of a bridge handshake.
    clear_prog();
    prog[0] = 32'h08000100;
    resp_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (py_req) found = 1'b1;
    end
    chk("r024.req_before", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("r024.abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("r024.restart_pc", pc, 32'h0);
    chk("r024.restart_state", 32'(dut.state), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (py_req) found = 1'b1;
    end
    chk("r024.req_again", 32'(found), 32'd1);
    chk("r024.req_pc", pc, 32'h0);
    chk("r024.req_addr", py_code_addr, 32'h1);
    resp_en = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/thiele_cpu.md
THIELE_CPU -- requirements
Module: thiele_cpu

Interface
REQ-001 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_data  in  32  instruction word at pc (combinational from pc).
- pc  out  32  byte address of the current instruction.
- cert_addr, status, error_code, partition_ops, mdl_ops, info_gain, mu  out  32 each  architectural registers.
- mem_addr, mem_wdata  out  32 each; mem_rdata  in  32; mem_we, mem_en  out  1 each  data-memory port.
- logic_req  out  1; logic_addr  out  32; logic_ack  in  1; logic_data  in  32  logic-engine handshake.
- py_req  out  1; py_code_addr  out  32; py_ack  in  1; py_result  in  32  Python-bridge handshake.
REQ-002 SHALL take opcode values from the shared generated_opcodes.vh header, including PNEW 0x00, PSPLIT 0x01, PMERGE 0x02, LASSERT 0x03, MDLACC 0x05, XFER 0x07, PYEXEC 0x08, EMIT 0x0E and HALT 0xFF.
REQ-003 SHALL expose internal regs state[3:0] and opcode[7:0] under exactly those names, so benches can probe them hierarchically.

Function
REQ-004 Instruction format SHALL be {opcode[31:24], a[23:16], b[15:8], cost[7:0]}.
REQ-005 SHALL use states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, LOGIC=4, PYTHON=5, COMPLETE=6.
REQ-006 FETCH SHALL latch instr_data and go to DECODE.
REQ-007 DECODE SHALL split the fields into opcode/a/b/cost and go to EXECUTE.
REQ-008 COMPLETE SHALL add cost to mu (mod 2^32), set pc=pc+4 and go to FETCH.
REQ-009 In EXECUTE, each opcode SHALL act as follows:
- PNEW/PSPLIT/PMERGE: partition_ops+=1, then COMPLETE.
- MDLACC: mdl_ops+=1, then COMPLETE.
- EMIT: info_gain+=b and cert_addr={16'h0,a,b}, then COMPLETE.
- XFER: go to MEMORY.
- LASSERT: go to LOGIC.
- PYEXEC: go to PYTHON.
- HALT: remain in EXECUTE with opcode=HALT, pc frozen, status[0]=1, no further fetches.
- Any other opcode: NOP, then COMPLETE.
REQ-010 PYTHON SHALL drive py_code_addr={16'h0,a,b} and hold py_req=1 until py_ack is sampled high. On that edge it SHALL drop py_req, latch py_result, and go to COMPLETE. If py_result is nonzero it SHALL set error_code=py_result and status[1]=1, and execution SHALL continue.
REQ-011 LOGIC SHALL follow the same handshake: logic_req with logic_addr={16'h0,a,b}. On logic_ack it SHALL set info_gain+=logic_data, drop logic_req, and go to COMPLETE.
REQ-012 MEMORY (XFER) SHALL take three cycles:
- cycle 1: mem_en=1, mem_we=0, mem_addr={24'h0,a}.
- cycle 2: capture mem_rdata.
- cycle 3: mem_en=1, mem_we=1, mem_addr={24'h0,b}, mem_wdata=captured word; then COMPLETE.
REQ-013 mem_en, mem_we, logic_req and py_req SHALL be 0 in all other states.
REQ-014 An ack already high on entry to LOGIC/PYTHON SHALL be accepted only after the corresponding req has been driven for at least one cycle.
REQ-015 All counters SHALL wrap at 2^32.
REQ-016 Acks arriving outside their wait state SHALL be ignored.

Reset
REQ-017 On rst_n=0, asynchronously:
- pc=0, state=FETCH, opcode=0.
- All 32-bit outputs=0; all req, en and we outputs=0.
REQ-018 Reset asserted mid-handshake SHALL abort the transaction, drop its req, and restart at pc=0 after release.

Verification
REQ-019 Program PYEXEC{08,00,01,01}, PYEXEC{08,00,02,01}, HALT{FF,00,00,00}, bridge acks one cycle later with rc=0 -> two requests with py_code_addr 0x1 then 0x2; then state=2, opcode=0xFF, pc=0x8, mu=2, status=0x1, error_code=0.
REQ-020 PYEXEC with py_result=5 -> error_code=5, status[1]=1, next instruction still executes.
REQ-021 PNEW, PSPLIT, MDLACC each with cost 3, then HALT -> partition_ops=2, mdl_ops=1, mu=9, pc=0xC.
REQ-022 EMIT{0E,12,34,00} -> cert_addr=0x1234, info_gain=0x34.
REQ-023 LASSERT with ack delayed 4 cycles and logic_data=7 -> logic_req held high until ack, then dropped; info_gain=7.
REQ-024 Reset pulsed while py_req=1 -> py_req=0 immediately, all outputs 0, fetch restarts at pc=0.
